// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - store buffer between the CPU data port and Data_Memory
// Stores queue in a circular FIFO and drain whenever no load holds the memory port.
module dmem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_memwrite,
  input  logic              cpu_memread,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_nonempty;
  logic              w_push;
  logic              w_drain;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_nonempty = (r_count != '0);
  // A full buffer refuses the push even if it drains this cycle.
  assign w_push     = RESET && cpu_memwrite && !w_full;
  assign w_drain    = RESET && !cpu_memread && w_nonempty;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + 1'b1;
      if (w_drain)
        r_head <= r_head + 1'b1;
      if (w_push && !w_drain)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_drain)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (w_push) begin
      r_addr[r_tail] <= cpu_addr;
      r_data[r_tail] <= cpu_wdata;
    end
  end

  // Oldest to youngest, so the last hit is the youngest matching store.
  // The head entry still matches in the cycle it drains.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && (r_addr[r_head + PTR_W'(i)] == cpu_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[r_head + PTR_W'(i)];
      end
    end
  end

  assign cpu_rdata    = w_fwd_hit ? w_fwd_data : mem_rdata;
  assign cpu_stall    = RESET && cpu_memwrite && w_full;
  assign buf_empty    = !w_nonempty;
  assign mem_memread  = RESET && cpu_memread;
  assign mem_memwrite = w_drain;
  assign mem_addr     = w_drain ? r_addr[r_head] : cpu_addr;
  assign mem_wdata    = w_drain ? r_data[r_head] : '0;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - scoreboard bench for dmem_write_buffer
module tb_dmem_write_buffer;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_rdata;
  logic        buf_empty;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mem_arr [64];
  logic [31:0] last_data;

  always #5 CLOCK = ~CLOCK;

  dmem_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_rdata(mem_rdata), .buf_empty(buf_empty)
  );

  assign mem_rdata = mem_arr[mem_addr[7:2]];

  always @(posedge CLOCK)
    if (mem_memwrite)
      mem_arr[mem_addr[7:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every memory write must be the next expected store, in order.
  always @(negedge CLOCK) begin
    if (mem_memwrite) begin
      if (exp_q.size() == 0)
        check("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
      else
        check("drain_order", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    cpu_memwrite = we;
    cpu_memread  = re;
    cpu_addr     = a;
    cpu_wdata    = d;
    #1;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    exp_q.push_back({a, d});
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    check("rst_memread", mem_memread, 1'b0);
    check("rst_rdata", cpu_rdata, mem_rdata);
    tick();
    tick();
    RESET = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("idle_empty", buf_empty, 1'b1);
    check("idle_memwrite", mem_memwrite, 1'b0);
    check("idle_memread", mem_memread, 1'b0);
    check("idle_stall", cpu_stall, 1'b0);
    tick();

    // Single store, drained the following cycle, then read back from memory.
    drive(1'b1, 1'b0, 32'h10, 32'hAAAA5555);
    check("st_no_drain", mem_memwrite, 1'b0);
    exp_q.push_back({32'h10, 32'hAAAA5555});
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("drain_we", mem_memwrite, 1'b1);
    check("drain_addr", mem_addr, 32'h10);
    check("drain_data", mem_wdata, 32'hAAAA5555);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("empty_after_drain", buf_empty, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    check("load_memread", mem_memread, 1'b1);
    check("load_from_mem", cpu_rdata, 32'hAAAA5555);
    tick();

    // Youngest buffered store wins over memory contents.
    store(32'h20, 32'h1);
    store(32'h20, 32'h2);
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    check("fwd_youngest", cpu_rdata, 32'h2);
    tick();
    idle(3);
    check("fwd_drained", exp_q.size(), 0);

    // Fill with load+store cycles (no drain), then stall for one cycle.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h0, 32'h100 + k);
      if (k > 0)
        check("fill_fwd_prestore", cpu_rdata, 32'h100 + k - 1);
      check("fill_no_stall", cpu_stall, 1'b0);
      exp_q.push_back({32'h0, 32'h100 + k});
      tick();
    end
    drive(1'b1, 1'b0, 32'h4, 32'h555);
    check("full_stall", cpu_stall, 1'b1);
    check("full_drain_we", mem_memwrite, 1'b1);
    check("full_drain_addr", mem_addr, 32'h0);
    check("full_drain_data", mem_wdata, 32'h100);
    tick();
    drive(1'b1, 1'b1, 32'h4, 32'h555);
    check("stall_one_cycle", cpu_stall, 1'b0);
    check("accept_no_drain", mem_memwrite, 1'b0);
    exp_q.push_back({32'h4, 32'h555});
    tick();
    drive(1'b1, 1'b1, 32'h8, 32'h666);
    check("count_back_to_full", cpu_stall, 1'b1);
    tick();
    idle(6);
    check("full_drained", exp_q.size(), 0);
    check("full_empty", buf_empty, 1'b1);

    // Ten stores with gaps; pointers wrap twice.
    last_data = 32'h0;
    for (int k = 0; k < 10; k++) begin
      last_data = $urandom;
      store(32'(k * 4), last_data);
      idle(1);
    end
    idle(2);
    check("wrap_drained", exp_q.size(), 0);
    drive(1'b0, 1'b1, 32'h24, 32'h0);
    check("wrap_readback", cpu_rdata, last_data);
    tick();

    // Reset with three buffered stores: they must never reach memory.
    drive(1'b1, 1'b1, 32'h50, 32'hA1);
    tick();
    drive(1'b1, 1'b1, 32'h54, 32'hB2);
    tick();
    drive(1'b1, 1'b1, 32'h54, 32'hC3);
    check("same_cycle_prestore", cpu_rdata, 32'hB2);
    tick();
    check("three_buffered", buf_empty, 1'b0);
    RESET = 1'b0;
    drive(1'b1, 1'b1, 32'h54, 32'h0);
    check("midrst_memwrite", mem_memwrite, 1'b0);
    check("midrst_memread", mem_memread, 1'b0);
    check("midrst_empty", buf_empty, 1'b1);
    check("midrst_stall", cpu_stall, 1'b0);
    check("midrst_rdata", cpu_rdata, mem_arr[6'h15]);
    tick();
    tick();
    RESET = 1'b1;
    idle(5);
    check("post_rst_empty", buf_empty, 1'b1);
    check("post_rst_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
